uart_bus_ctrl: RTL and testbench
================================

# uart_bus_ctrl

Bus-side controller that sits between the Wishbone slave port and the UART transmitter/receiver pair. It buffers CPU writes in a TX FIFO and sequences one transmitter start per byte using the transmitter's busy flag. It captures received bytes into an RX buffer with overrun detection, exposes data/status/control registers, and drives a level interrupt.

## Interface
Parameters:
- TX_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 4, RX FIFO entries when RX FIFO is compiled in (power of two, ≥2)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-low reset
- bus_addr_i  in  `WB_AddrBus  byte address; bits [3:2] select register
- bus_data_i  in  `WB_DataBus  write data
- bus_data_o  out  `WB_DataBus  read data, valid while bus_ack_o=1
- bus_select_i  in  1  access request, held until ack
- bus_we_i  in  1  1=write, 0=read
- bus_ack_o  out  1  one-cycle access completion
- tx_start_o  out  1  one-cycle start pulse to transmitter
- tx_data_o  out  `UartDataBus  byte to send, stable from start pulse until busy falls
- tx_busy_i  in  1  transmitter busy
- rx_data_i  in  `UartDataBus  received byte
- rx_ready_i  in  1  one-cycle pulse, rx_data_i valid
- irq_o  out  1  level interrupt

## Operation
- Register map, addr[3:2]:
  - 0 DATA: a write pushes data[7:0] into the TX FIFO. A read pops the RX head and returns it zero-extended. Reading with RX empty returns 0 and does not pop.
  - 1 STATUS, read: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun, bit4 tx_active (FSM not IDLE). Other bits read 0. Writing 1 to bit3 clears overrun; other write bits are ignored.
  - 2 CTRL, read/write: bit0 rx_irq_en, bit1 tx_irq_en.
  - 3: reads 0, writes ignored, still acked.
- Bus handshake: an access is accepted when bus_select_i=1 and bus_ack_o=0. bus_ack_o pulses the following cycle, then stays low for at least one cycle.
- A DATA write while the TX FIFO is full is withheld (no ack) until an entry frees. It is then accepted and acked the cycle after.
- TX FSM:
  - IDLE: if the FIFO is non-empty, latch the head into tx_data_o, pop it, and go to LAUNCH.
  - LAUNCH: tx_start_o=1 for one cycle, then WAIT_HI.
  - WAIT_HI: wait for tx_busy_i=1, then WAIT_LO. If 2 cycles pass without busy, go to WAIT_LO anyway.
  - WAIT_LO: wait for tx_busy_i=0, then IDLE.
- RX: on rx_ready_i, push rx_data_i.
  - If the RX buffer is full, the byte is dropped, rx_overrun is set, and the old contents are kept.
  - A push and a pop in the same cycle are both honoured, including when full: the pop occurs first, so no overrun.
- irq_o = (rx_irq_en & (rx_valid | rx_overrun)) | (tx_irq_en & tx_empty & FSM==IDLE). Registered.

## Timing
- Reset values:
  - bus_ack_o=0, bus_data_o=0, tx_start_o=0, tx_data_o=0, irq_o=0.
  - FIFOs empty, overrun=0, CTRL=0, FSM=IDLE.
- Reset mid-transmission: the FSM returns to IDLE and queued bytes are discarded. The byte already started in the transmitter is not aborted.
- Read latency: 1 cycle, select to ack with data. Write latency: 1 cycle, or more if the TX FIFO is full.
- Write to tx_start_o with FSM idle and FIFO empty: DATA write ack at cycle N+1, FIFO non-empty at N+1, LAUNCH at N+2, tx_start_o at N+2.
- A status read returns the state from the cycle before ack.
- irq_o lags its condition by 1 cycle.
- FIFO pointers wrap modulo depth. Each FIFO carries one extra pointer bit to tell full from empty.

## Configuration
- UART_CTRL_RX_FIFO_EN defined: the RX path is an RX_DEPTH-entry FIFO.
- UART_CTRL_RX_FIFO_EN undefined: the RX path is a single holding register, effective depth 1. A second byte arriving before the DATA read sets overrun. The RX_DEPTH parameter is ignored.
- The register map is identical in both builds.

## Structure
- defines.v: register offsets (UART_REG_DATA/STATUS/CTRL), STATUS/CTRL bit indices, TX FSM state encodings (2-bit), and reuse of `UartDataBus / `WB_* buses.
- Sub-module uart_ctrl_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/full/empty/head. Instantiated for TX always, and for RX when the macro is defined.

## Test plan
- Reset, then read STATUS → 0x00000002 (tx_empty only). irq_o=0. tx_start_o never pulses.
- Write 0x41, 0x42 to DATA, with the transmitter model holding busy for 20 cycles → two tx_start_o pulses, with tx_data_o 0x41 then 0x42. The second pulse comes only after busy has fallen. STATUS ends at 0x02.
- Fill the TX FIFO with 8 writes while busy is held, then make a 9th write → no ack until the first pop. The 9th byte is eventually transmitted in order.
- Inject 5 rx_ready_i pulses (0x10..0x14) without reads, with the FIFO build at RX_DEPTH=4 → STATUS bit3=1. DATA reads return 0x10..0x13, then a 5th read returns 0. Writing STATUS 0x08 clears overrun.
- rx_ready_i in the same cycle as a DATA read acceptance with the RX buffer full → no overrun, and the new byte is the last returned.
- Set CTRL=0x1, inject byte 0x55 → irq_o rises 2 cycles after rx_ready_i and falls 1 cycle after the DATA read ack.

Source files
------------

// File: rtl/uart_bus_ctrl_pkg.sv
// Shared widths, register offsets, STATUS/CTRL bit positions and TX FSM encoding
// for the UART bus controller.
package uart_bus_ctrl_pkg;

  localparam int unsigned WbAddrW   = 32;
  localparam int unsigned WbDataW   = 32;
  localparam int unsigned UartDataW = 8;

  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2,
    RegRsvd   = 2'd3
  } reg_addr_e;

  localparam int unsigned StTxFull    = 0;
  localparam int unsigned StTxEmpty   = 1;
  localparam int unsigned StRxValid   = 2;
  localparam int unsigned StRxOverrun = 3;
  localparam int unsigned StTxActive  = 4;

  localparam int unsigned CtrlRxIrqEn = 0;
  localparam int unsigned CtrlTxIrqEn = 1;

  typedef enum logic [1:0] {
    TxIdle   = 2'd0,
    TxLaunch = 2'd1,
    TxWaitHi = 2'd2,
    TxWaitLo = 2'd3
  } tx_state_e;

  function automatic logic [WbDataW-1:0] zext_byte(input logic [UartDataW-1:0] b);
    return {{(WbDataW - UartDataW){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_ctrl_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to separate full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_ctrl_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Wishbone-side UART controller: TX FIFO + start sequencer, RX buffer, registers, irq.
// UART_CTRL_RX_FIFO_EN selects an RX_DEPTH FIFO; otherwise RX is a single holding register.
module uart_bus_ctrl
  import uart_bus_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WbAddrW-1:0]   bus_addr_i,
  input  logic [WbDataW-1:0]   bus_data_i,
  output logic [WbDataW-1:0]   bus_data_o,
  input  logic                 bus_select_i,
  input  logic                 bus_we_i,
  output logic                 bus_ack_o,
  output logic                 tx_start_o,
  output logic [UartDataW-1:0] tx_data_o,
  input  logic                 tx_busy_i,
  input  logic [UartDataW-1:0] rx_data_i,
  input  logic                 rx_ready_i,
  output logic                 irq_o
);

  reg_addr_e              reg_sel;
  logic                   wr_block, accept, rd_acc, wr_acc;
  logic                   ack_q;
  logic [WbDataW-1:0]     rdata, rdata_q;
  logic [1:0]             ctrl_q;
  logic                   overrun_q, rx_drop, ovr_clr;
  logic                   tx_push, tx_pop, tx_full, tx_empty;
  logic [UartDataW-1:0]   tx_head;
  logic                   rx_pop, rx_full, rx_empty, rx_valid;
  logic [UartDataW-1:0]   rx_head;
  tx_state_e              tx_state_q;
  logic                   tx_start_q;
  logic [UartDataW-1:0]   tx_data_q;
  logic                   wait_cnt_q;
  logic                   irq_q;
  logic                   unused_bus;

  assign unused_bus = ^{bus_addr_i[WbAddrW-1:4], bus_addr_i[1:0], bus_data_i[WbDataW-1:8]};

  // A DATA write into a full TX FIFO stalls the bus until the sequencer pops.
  assign reg_sel  = reg_addr_e'(bus_addr_i[3:2]);
  assign wr_block = bus_we_i && (reg_sel == RegData) && tx_full;
  assign accept   = bus_select_i && !ack_q && !wr_block;
  assign rd_acc   = accept && !bus_we_i;
  assign wr_acc   = accept && bus_we_i;
  assign tx_push  = wr_acc && (reg_sel == RegData);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rd_acc && (reg_sel == RegData) && rx_valid;
  assign rx_drop  = rx_ready_i && rx_full && !rx_pop;
  assign ovr_clr  = wr_acc && (reg_sel == RegStatus) && bus_data_i[StRxOverrun];
  assign tx_pop   = (tx_state_q == TxIdle) && !tx_empty;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegData: if (rx_valid) rdata = zext_byte(rx_head);
      RegStatus: begin
        rdata[StTxFull]    = tx_full;
        rdata[StTxEmpty]   = tx_empty;
        rdata[StRxValid]   = rx_valid;
        rdata[StRxOverrun] = overrun_q;
        rdata[StTxActive]  = (tx_state_q != TxIdle);
      end
      RegCtrl: rdata[1:0] = ctrl_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q   <= accept;
      rdata_q <= rd_acc ? rdata : '0;
      if (wr_acc && (reg_sel == RegCtrl)) ctrl_q <= bus_data_i[1:0];
      if (rx_drop)      overrun_q <= 1'b1;
      else if (ovr_clr) overrun_q <= 1'b0;
      irq_q <= (ctrl_q[CtrlRxIrqEn] & (rx_valid | overrun_q)) |
               (ctrl_q[CtrlTxIrqEn] & tx_empty & (tx_state_q == TxIdle));
    end
  end

  uart_ctrl_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (UartDataW)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (bus_data_i[UartDataW-1:0]),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

`ifdef UART_CTRL_RX_FIFO_EN
  uart_ctrl_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (UartDataW)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_ready_i),
    .pop_i   (rx_pop),
    .data_i  (rx_data_i),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );
`else
  logic                 rx_valid_q;
  logic [UartDataW-1:0] rx_hold_q;
  logic [31:0]          unused_rx_depth;

  assign unused_rx_depth = RX_DEPTH;
  assign rx_full  = rx_valid_q;
  assign rx_empty = !rx_valid_q;
  assign rx_head  = rx_hold_q;

  // A read in the same cycle frees the register, so the new byte replaces it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_valid_q <= 1'b0;
      rx_hold_q  <= '0;
    end else if (rx_ready_i && (!rx_valid_q || rx_pop)) begin
      rx_valid_q <= 1'b1;
      rx_hold_q  <= rx_data_i;
    end else if (rx_pop) begin
      rx_valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wait_cnt_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (tx_state_q)
        TxIdle: begin
          if (!tx_empty) begin
            tx_data_q  <= tx_head;
            tx_start_q <= 1'b1;
            tx_state_q <= TxLaunch;
          end
        end
        TxLaunch: begin
          wait_cnt_q <= 1'b0;
          tx_state_q <= TxWaitHi;
        end
        // Give up on busy after two cycles so a silent transmitter cannot hang us.
        TxWaitHi: begin
          if (tx_busy_i || wait_cnt_q) tx_state_q <= TxWaitLo;
          else                         wait_cnt_q <= 1'b1;
        end
        TxWaitLo: begin
          if (!tx_busy_i) tx_state_q <= TxIdle;
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign bus_ack_o  = ack_q;
  assign bus_data_o = rdata_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl: register table, directed corner cases,
// and a randomized phase against a queue-based model of the RX/TX behaviour.
module tb_uart_bus_ctrl;

`ifdef UART_CTRL_RX_FIFO_EN
  localparam int RxEff = 4;
`else
  localparam int RxEff = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr_i, bus_data_i, bus_data_o;
  logic        bus_select_i, bus_we_i, bus_ack_o;
  logic        tx_start_o, tx_busy_i;
  logic [7:0]  tx_data_o, rx_data_i;
  logic        rx_ready_i, irq_o;

  always #5 clk = ~clk;

  uart_bus_ctrl #(
    .TX_DEPTH (8),
    .RX_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .bus_addr_i   (bus_addr_i),
    .bus_data_i   (bus_data_i),
    .bus_data_o   (bus_data_o),
    .bus_select_i (bus_select_i),
    .bus_we_i     (bus_we_i),
    .bus_ack_o    (bus_ack_o),
    .tx_start_o   (tx_start_o),
    .tx_data_o    (tx_data_o),
    .tx_busy_i    (tx_busy_i),
    .rx_data_i    (rx_data_i),
    .rx_ready_i   (rx_ready_i),
    .irq_o        (irq_o)
  );

  int checks = 0;
  int failures = 0;

  // Transmitter model: busy for busy_len cycles after each start pulse.
  logic       busy_m;
  int         busy_cnt;
  int         busy_len = 5;
  logic [7:0] last_sent;
  logic [7:0] sent_q[$];
  logic [7:0] exp_tx[$];
  int         start_bad = 0;
  int         data_bad = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      busy_m   <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start_o) begin
      if (busy_m) start_bad++;
      sent_q.push_back(tx_data_o);
      last_sent <= tx_data_o;
      busy_m    <= 1'b1;
      busy_cnt  <= busy_len;
    end else if (busy_m) begin
      if (tx_data_o !== last_sent) data_bad++;
      if (busy_cnt <= 1) busy_m <= 1'b0;
      else               busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy_i = busy_m;

  // RX / control model
  logic [7:0] rxq[$];
  bit         ovr_m = 1'b0;
  bit [1:0]   ctrl_m = 2'b00;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=ack", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    bit got = 1'b0;
    d = '0;
    bus_addr_i = a; bus_we_i = 1'b0; bus_select_i = 1'b1;
    while (!got && n < 100) begin
      tick(); n++;
      if (bus_ack_o) begin got = 1'b1; d = bus_data_o; end
    end
    bus_select_i = 1'b0;
    if (!got) fail_now("read_ack");
    else begin
      check("read_latency", n, 1);
      tick();
      check("ack_low_after_read", {31'b0, bus_ack_o}, 0);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bit got = 1'b0;
    bus_addr_i = a; bus_data_i = d; bus_we_i = 1'b1; bus_select_i = 1'b1;
    while (!got && n < 500) begin
      tick(); n++;
      if (bus_ack_o) got = 1'b1;
    end
    bus_select_i = 1'b0; bus_we_i = 1'b0;
    if (!got) fail_now("write_ack");
    else begin
      if (a[3:2] == 2'd0) exp_tx.push_back(d[7:0]);
      tick();
      check("ack_low_after_write", {31'b0, bus_ack_o}, 0);
    end
  endtask

  task automatic rx_inject(input logic [7:0] b);
    rx_data_i = b; rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    if (rxq.size() < RxEff) rxq.push_back(b);
    else                    ovr_m = 1'b1;
  endtask

  function automatic logic [31:0] model_pop();
    if (rxq.size() == 0) return 32'h0;
    return {24'h0, rxq.pop_front()};
  endfunction

  // STATUS as expected with the transmitter side idle and drained.
  function automatic logic [31:0] exp_status();
    return {28'h0, ovr_m, rxq.size() > 0, 1'b1, 1'b0};
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (n < 3000 && !(sent_q.size() == exp_tx.size() && !busy_m)) begin
      tick(); n++;
    end
    if (n >= 3000) fail_now("tx_drain");
    repeat (4) tick();
  endtask

  task automatic compare_tx();
    int m;
    check("tx_count", sent_q.size(), exp_tx.size());
    m = (sent_q.size() < exp_tx.size()) ? sent_q.size() : exp_tx.size();
    for (int i = 0; i < m; i++) check("tx_byte", {24'h0, sent_q[i]}, {24'h0, exp_tx[i]});
    sent_q.delete();
    exp_tx.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e;
    int          acks;
    int          op;
    logic [7:0]  b;

    vecs[0]  = '{1'b0, 32'h4, 32'h0,         32'h2};
    vecs[1]  = '{1'b0, 32'h8, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 32'hC, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 32'h0, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 32'h8, 32'h3,         32'h0};
    vecs[5]  = '{1'b0, 32'h8, 32'h0,         32'h3};
    vecs[6]  = '{1'b1, 32'h8, 32'hFFFF_FFFC, 32'h0};
    vecs[7]  = '{1'b0, 32'h8, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 32'hC, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 32'hC, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 32'h4, 32'hFFFF_FFF7, 32'h0};
    vecs[11] = '{1'b0, 32'h7, 32'h0,         32'h2};

    rst_n = 1'b0;
    bus_addr_i = '0; bus_data_i = '0; bus_select_i = 1'b0; bus_we_i = 1'b0;
    rx_data_i = '0; rx_ready_i = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {bus_ack_o, tx_start_o, irq_o, tx_data_o}, 0);
    check("reset_bus_data", bus_data_o, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_start_after_reset", sent_q.size(), 0);
    check("irq_after_reset", {31'b0, irq_o}, 0);

    // Register table
    foreach (vecs[i]) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("table_%0d", i), rd, vecs[i].exp);
      end
    end
    repeat (2) tick();
    check("irq_ctrl_zero", {31'b0, irq_o}, 0);

    // Write-to-start latency, then a second byte held behind busy
    busy_len = 20;
    bus_addr_i = 32'h0; bus_we_i = 1'b1; bus_data_i = 32'h41; bus_select_i = 1'b1;
    tick();
    check("wr_ack_n1", {31'b0, bus_ack_o}, 1);
    check("no_start_n1", {31'b0, tx_start_o}, 0);
    bus_select_i = 1'b0; bus_we_i = 1'b0;
    exp_tx.push_back(8'h41);
    tick();
    check("start_n2", {31'b0, tx_start_o}, 1);
    check("tx_data_n2", {24'h0, tx_data_o}, 32'h41);
    tick();
    check("start_one_cycle", {31'b0, tx_start_o}, 0);
    bus_write(32'h0, 32'h42);
    bus_read(32'h4, rd);
    check("status_active_pending", rd, 32'h10);
    wait_drain();
    compare_tx();
    bus_read(32'h4, rd);
    check("status_after_two", rd, 32'h2);

    // Full TX FIFO withholds the ninth write
    busy_len = 60;
    bus_write(32'h0, 32'h60);
    repeat (3) tick();
    for (int i = 1; i <= 8; i++) bus_write(32'h0, 32'h60 + i);
    bus_read(32'h4, rd);
    check("status_full", rd, 32'h11);
    bus_addr_i = 32'h0; bus_we_i = 1'b1; bus_data_i = 32'h69; bus_select_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_ack_o) acks++;
    end
    check("full_write_withheld", acks, 0);
    begin
      int n = 0;
      while (!bus_ack_o && n < 300) begin tick(); n++; end
      if (!bus_ack_o) fail_now("full_write_ack");
      else exp_tx.push_back(8'h69);
    end
    bus_select_i = 1'b0; bus_we_i = 1'b0;
    tick();
    wait_drain();
    compare_tx();
    busy_len = 5;

    // RX overrun
    for (int i = 0; i < 5; i++) rx_inject(8'h10 + i);
    bus_read(32'h4, rd);
    check("status_overrun", rd, exp_status());
    for (int i = 0; i < 5; i++) begin
      e = model_pop();
      bus_read(32'h0, rd);
      check("rx_read", rd, e);
    end
    bus_read(32'h4, rd);
    check("status_ovr_kept", rd, exp_status());
    bus_write(32'h4, 32'h8);
    ovr_m = 1'b0;
    bus_read(32'h4, rd);
    check("status_ovr_cleared", rd, exp_status());

    // rx_ready in the same cycle as a DATA read acceptance, buffer full
    for (int i = 0; i < RxEff; i++) rx_inject(8'h20 + i);
    bus_addr_i = 32'h0; bus_we_i = 1'b0; bus_select_i = 1'b1;
    rx_data_i = 8'h2F; rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0; bus_select_i = 1'b0;
    e = model_pop();
    rxq.push_back(8'h2F);
    check("same_cycle_ack", {31'b0, bus_ack_o}, 1);
    check("same_cycle_data", bus_data_o, e);
    tick();
    bus_read(32'h4, rd);
    check("same_cycle_no_ovr", rd, exp_status());
    while (rxq.size() > 0) begin
      e = model_pop();
      bus_read(32'h0, rd);
      check("same_cycle_drain", rd, e);
    end
    check("same_cycle_last", e, 32'h2F);

    // RX interrupt timing
    bus_write(32'h8, 32'h1);
    ctrl_m = 2'b01;
    repeat (2) tick();
    check("irq_idle", {31'b0, irq_o}, 0);
    rx_data_i = 8'h55; rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    check("irq_r_plus1", {31'b0, irq_o}, 0);
    tick();
    check("irq_r_plus2", {31'b0, irq_o}, 1);
    bus_addr_i = 32'h0; bus_we_i = 1'b0; bus_select_i = 1'b1;
    tick();
    bus_select_i = 1'b0;
    check("irq_read_data", bus_data_o, 32'h55);
    check("irq_at_ack", {31'b0, irq_o}, 1);
    tick();
    check("irq_fall", {31'b0, irq_o}, 0);

    // Randomized phase against the model
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: rx_inject(8'($urandom));
        1: begin
          e = model_pop();
          bus_read(32'h0, rd);
          check("rnd_data", rd, e);
        end
        2: begin
          bus_read(32'h4, rd);
          check("rnd_status", rd & 32'hFFFF_FFEC, {28'h0, ovr_m, rxq.size() > 0, 2'b00});
        end
        3: begin
          rd = $urandom;
          bus_write(32'h4, rd);
          if (rd[3]) ovr_m = 1'b0;
        end
        4: begin
          busy_len = $urandom_range(1, 6);
          bus_write(32'h0, $urandom);
        end
        default: begin
          rd = $urandom;
          bus_write(32'h8, rd);
          ctrl_m = rd[1:0];
          bus_read(32'h8, rd);
          check("rnd_ctrl", rd, {30'h0, ctrl_m});
        end
      endcase
      repeat (2) tick();
      if (!ctrl_m[1])
        check("rnd_irq", {31'b0, irq_o}, {31'b0, ctrl_m[0] & (ovr_m | (rxq.size() > 0))});
    end
    wait_drain();
    compare_tx();

    // TX-empty interrupt once drained
    bus_write(32'h8, 32'h2);
    repeat (2) tick();
    check("irq_tx_empty", {31'b0, irq_o}, 1);
    bus_write(32'h8, 32'h0);
    repeat (2) tick();
    check("irq_off", {31'b0, irq_o}, 0);

    check("start_while_busy", start_bad, 0);
    check("tx_data_unstable", data_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
